// File: rtl/dcache_ctrl_if.sv
// Core-side and memory-side word buses of the direct-mapped data cache controller.
interface dcache_cpu_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        stall;

    modport master (output cpu_req, cpu_we, cpu_addr, cpu_wdata, input cpu_rdata, stall);
    modport slave  (input cpu_req, cpu_we, cpu_addr, cpu_wdata, output cpu_rdata, stall);
endinterface

interface dcache_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_we, mem_addr, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with line refill.
// Define DCACHE_STATS_EN to add the hit_count / miss_count load statistics outputs.
module dcache_ctrl #(
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic         clock,
    input  logic         reset,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(NUM_LINES);
    localparam int TB = 30 - OB - IB;

    typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

    state_t state, state_next;

    logic [31:0]          data_mem [NUM_LINES][LINE_WORDS];
    logic [TB-1:0]        tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0] valid;

    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [OB-1:0] cnt;
    logic          refilled_q;

    logic [OB-1:0] cpu_off;
    logic [IB-1:0] cpu_idx, q_idx;
    logic [TB-1:0] cpu_tag, q_tag;
    logic [OB-1:0] q_off;
    logic          cpu_hit, q_hit, last_word;
    logic          unused_addr_bits;

    assign cpu_off = cpu.cpu_addr[OB+1:2];
    assign cpu_idx = cpu.cpu_addr[OB+2 +: IB];
    assign cpu_tag = cpu.cpu_addr[31 -: TB];
    assign q_off   = addr_q[OB+1:2];
    assign q_idx   = addr_q[OB+2 +: IB];
    assign q_tag   = addr_q[31 -: TB];

    assign cpu_hit   = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
    assign q_hit     = valid[q_idx] && (tag_mem[q_idx] == q_tag);
    assign last_word = &cnt;

    assign cpu.cpu_rdata   = data_mem[cpu_idx][cpu_off];
    assign mem.mem_wdata   = wdata_q;
    assign unused_addr_bits = ^cpu.cpu_addr[1:0];

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (cpu.cpu_req) begin
                    if (cpu.cpu_we)    state_next = WRITE;
                    else if (!cpu_hit) state_next = REFILL;
                end
            end
            REFILL:  if (mem.mem_ack && last_word) state_next = IDLE;
            WRITE:   if (mem.mem_ack)              state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cpu.stall    = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.mem_addr = addr_q;
        case (state)
            IDLE: cpu.stall = cpu.cpu_req && (cpu.cpu_we || !cpu_hit);
            REFILL: begin
                cpu.stall    = 1'b1;
                mem.mem_req  = 1'b1;
                // Line base keeps the tag/index; the counter selects the word, so no carry can leave the line.
                mem.mem_addr = {addr_q[31:OB+2], cnt, 2'b00};
            end
            WRITE: begin
                cpu.stall   = !mem.mem_ack;
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            valid      <= '0;
            refilled_q <= 1'b0;
        end else begin
            refilled_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu.cpu_req && cpu.cpu_we) begin
                        addr_q  <= {cpu.cpu_addr[31:2], 2'b00};
                        wdata_q <= cpu.cpu_wdata;
                    end else if (cpu.cpu_req && !cpu_hit) begin
                        addr_q <= {cpu.cpu_addr[31:OB+2], {(OB+2){1'b0}}};
                        cnt    <= '0;
                    end
                end
                REFILL: begin
                    if (mem.mem_ack) begin
                        cnt <= cnt + 1'b1;
                        if (last_word) begin
                            valid[q_idx] <= 1'b1;
                            refilled_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: data and tag arrays carry no reset; the cleared valid bits make their contents unobservable.
    always_ff @(posedge clock) begin
        if (reset) begin
            if (state == REFILL && mem.mem_ack) begin
                data_mem[q_idx][cnt] <= mem.mem_rdata;
                if (last_word) tag_mem[q_idx] <= q_tag;
            end
            if (state == WRITE && mem.mem_ack && q_hit) data_mem[q_idx][q_off] <= wdata_q;
        end
    end

`ifdef DCACHE_STATS_EN
    // A load re-presented right after its own refill is the tail of a miss, not a fresh hit.
    always_ff @(posedge clock) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (state == IDLE && cpu.cpu_req && !cpu.cpu_we) begin
            if (cpu_hit && !refilled_q) hit_count  <= hit_count + 32'd1;
            else if (!cpu_hit)          miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: memory responder with a scoreboard of expected bus operations and load data.
module tb_dcache_ctrl;
    localparam int ACK_LAT = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_op_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    dcache_cpu_if cpu_bus ();
    dcache_mem_if mem_bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    dcache_ctrl #(.NUM_LINES(16), .LINE_WORDS(4)) dut (
        .clock (clock),
        .reset (reset),
        .cpu   (cpu_bus),
        .mem   (mem_bus)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    always #5 clock = ~clock;

    int n_checks   = 0;
    int n_pass     = 0;
    int n_acks     = 0;
    int exp_hits   = 0;
    int exp_misses = 0;

    logic [31:0] ref_mem [logic [31:0]];
    mem_op_t     exp_mem_q [$];
    logic [31:0] exp_rdata_q [$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Backing memory: acks each request ACK_LAT negedges after it is seen, one cycle wide.
    initial begin : mem_model
        int wait_cnt;
        mem_op_t e;
        wait_cnt          = 0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        forever begin
            @(negedge clock);
            if (!reset || mem_bus.mem_ack) begin
                mem_bus.mem_ack = 1'b0;
                wait_cnt        = 0;
            end else if (mem_bus.mem_req) begin
                wait_cnt++;
                if (wait_cnt == ACK_LAT) begin
                    n_acks++;
                    check("mem_op_expected", 32'(exp_mem_q.size() != 0), 32'd1);
                    if (exp_mem_q.size() != 0) begin
                        e = exp_mem_q.pop_front();
                        check("mem_we", 32'(mem_bus.mem_we), 32'(e.we));
                        check("mem_addr", mem_bus.mem_addr, e.addr);
                        if (e.we) check("mem_wdata", mem_bus.mem_wdata, e.wdata);
                    end
                    mem_bus.mem_rdata = mem_bus.mem_we ? 32'h0 : mem_word(mem_bus.mem_addr);
                    mem_bus.mem_ack   = 1'b1;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_load(input logic [31:0] a, input bit miss);
        logic [31:0] base;
        bit stalled;
        bit done;
        base    = {a[31:4], 4'h0};
        stalled = 1'b0;
        done    = 1'b0;
        if (miss) begin
            for (int w = 0; w < 4; w++) exp_mem_q.push_back('{we: 1'b0, addr: base + 32'(4 * w), wdata: 32'h0});
            exp_misses++;
        end else begin
            exp_hits++;
        end
        exp_rdata_q.push_back(mem_word({a[31:2], 2'b00}));
        @(negedge clock);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = a;
        cpu_bus.cpu_wdata = 32'h0;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (!cpu_bus.stall) done = 1'b1;
            else begin
                stalled = 1'b1;
                @(negedge clock);
            end
        end
        check("load_done", 32'(done), 32'd1);
        check("load_rdata", cpu_bus.cpu_rdata, exp_rdata_q.pop_front());
        check("load_stalled", 32'(stalled), 32'(miss));
        check("load_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("refill_words_left", 32'(exp_mem_q.size()), 32'd0);
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bit stalled;
        bit done;
        stalled = 1'b0;
        done    = 1'b0;
        exp_mem_q.push_back('{we: 1'b1, addr: {a[31:2], 2'b00}, wdata: d});
        ref_mem[{a[31:2], 2'b00}] = d;
        @(negedge clock);
        cpu_bus.cpu_req   = 1'b1;
        cpu_bus.cpu_we    = 1'b1;
        cpu_bus.cpu_addr  = a;
        cpu_bus.cpu_wdata = d;
        for (int c = 0; c < 100 && !done; c++) begin
            #1;
            if (!cpu_bus.stall) done = 1'b1;
            else begin
                stalled = 1'b1;
                @(negedge clock);
            end
        end
        check("store_done", 32'(done), 32'd1);
        check("store_stalled", 32'(stalled), 32'd1);
        check("store_release_on_ack", 32'(mem_bus.mem_ack), 32'd1);
        check("store_ops_left", 32'(exp_mem_q.size()), 32'd0);
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        cpu_bus.cpu_req = 1'b0;
        cpu_bus.cpu_we  = 1'b0;
    endtask

    initial begin : stimulus
        bit hit_third;
        cpu_bus.cpu_req   = 1'b0;
        cpu_bus.cpu_we    = 1'b0;
        cpu_bus.cpu_addr  = 32'h0;
        cpu_bus.cpu_wdata = 32'h0;
        ref_mem[32'h40] = 32'h11;
        ref_mem[32'h44] = 32'h22;
        ref_mem[32'h48] = 32'h33;
        ref_mem[32'h4C] = 32'h44;

        reset = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_stall", 32'(cpu_bus.stall), 32'd0);
        check("rst_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_bus.mem_we), 32'd0);
        check("rst_mem_addr", mem_bus.mem_addr, 32'h0);
        check("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_count", hit_count, 32'd0);
        check("rst_miss_count", miss_count, 32'd0);
`endif
        reset = 1'b1;
        idle_cycle();

        do_load(32'h0000_0040, 1'b1);
        do_load(32'h0000_0048, 1'b0);
        do_store(32'h0000_0044, 32'hDEAD_BEEF);
        do_load(32'h0000_0044, 1'b0);
        check("store_hit_data", cpu_bus.cpu_rdata, 32'hDEAD_BEEF);

        do_store(32'h0000_1000, 32'hCAFE_0001);
        do_load(32'h0000_1000, 1'b1);

        // Same index as 0x40 but a different tag: memory updates, cached line must not.
        do_store(32'h0000_0144, 32'h0BAD_F00D);
        do_load(32'h0000_0044, 1'b0);

        do_load(32'h0000_0040, 1'b0);
        do_load(32'h0000_0140, 1'b1);
        do_load(32'h0000_0040, 1'b1);
        do_load(32'h0000_004C, 1'b0);
        idle_cycle();

        // Abort a refill of 0x140 while its third word is outstanding.
        for (int w = 0; w < 4; w++) exp_mem_q.push_back('{we: 1'b0, addr: 32'h140 + 32'(4 * w), wdata: 32'h0});
        @(negedge clock);
        cpu_bus.cpu_req  = 1'b1;
        cpu_bus.cpu_we   = 1'b0;
        cpu_bus.cpu_addr = 32'h0000_0140;
        hit_third = 1'b0;
        begin
            int start_acks;
            start_acks = n_acks;
            for (int c = 0; c < 100 && !hit_third; c++) begin
                #1;
                if (n_acks == start_acks + 2 && !mem_bus.mem_ack) hit_third = 1'b1;
                else @(negedge clock);
            end
        end
        check("third_word_reached", 32'(hit_third), 32'd1);
        reset           = 1'b0;
        cpu_bus.cpu_req = 1'b0;
        @(negedge clock);
        #1;
        check("abort_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("abort_stall", 32'(cpu_bus.stall), 32'd0);
        check("abort_mem_we", 32'(mem_bus.mem_we), 32'd0);
        check("abort_mem_addr", mem_bus.mem_addr, 32'h0);
`ifdef DCACHE_STATS_EN
        check("abort_hit_count", hit_count, 32'd0);
        check("abort_miss_count", miss_count, 32'd0);
`endif
        reset = 1'b1;
        check("discarded_words", 32'(exp_mem_q.size()), 32'd2);
        exp_mem_q.delete();
        exp_hits   = 0;
        exp_misses = 0;

        do_load(32'h0000_0040, 1'b1);
        do_load(32'h0000_0044, 1'b0);
        idle_cycle();
        repeat (4) @(negedge clock);
        #1;
        check("idle_mem_req", 32'(mem_bus.mem_req), 32'd0);
        check("no_stray_ops", 32'(exp_mem_q.size()), 32'd0);
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'(exp_hits));
        check("miss_count", miss_count, 32'(exp_misses));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller.
- It is the responder for the datapath's data-memory accesses: it takes the ALUResult address and WriteData, and returns read data plus the `stall` that freezes the PC.
- Behind it, it acts as initiator to backing memory over a req/ack word interface.
- Misses refill a whole line by issuing sequential word reads.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2, ≥2).
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2).

Ports:
- clock  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- cpu_req  input  1  core issues load/store this cycle.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_addr  input  32  byte address; bits [1:0] ignored.
- cpu_wdata  input  32  store data.
- cpu_rdata  output  32  load data, valid when cpu_req & ~cpu_we & ~stall.
- stall  output  1  hold core/PC; combinational.
- mem_req  output  1  backing-memory request, held until mem_ack.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  32  word-aligned memory address.
- mem_wdata  output  32  memory write data.
- mem_ack  input  1  one-cycle completion; mem_rdata valid with it.
- mem_rdata  input  32  memory read data.

Behaviour:
- Address split: offset = addr[OB+1:2], with OB = log2(LINE_WORDS). Index = next log2(NUM_LINES) bits. Tag = remaining upper bits.
- Storage: data array, tag array, and per-line valid bit. Valid bits are cleared on reset; data and tags are not.
- hit = valid[index] & (tag[index] == cpu tag).
- FSM states: IDLE, REFILL, WRITE.
- IDLE, no cpu_req: stall=0, mem_req=0.
- IDLE, load hit: stall=0, cpu_rdata = data[index][offset] combinationally (zero latency). State stays IDLE.
- IDLE, load miss: stall=1. Latch line base address (offset bits and [1:0] = 0). Clear word counter. Go to REFILL.
- REFILL: mem_req=1, mem_we=0, mem_addr = base + 4*counter, stall=1.
  - On mem_ack: write mem_rdata into data[index][counter] and increment the counter.
  - On the ack for word LINE_WORDS-1: write tag, set valid, go to IDLE.
  - The next cycle the load hits, so stall=0. Miss penalty is LINE_WORDS acks plus 1 cycle.
- IDLE, any store: latch address/data, go to WRITE, stall=1. Hits and misses are handled alike.
- WRITE: mem_req=1, mem_we=1, mem_addr/mem_wdata = latched values.
  - stall = ~mem_ack, so the core advances on the ack edge.
  - On ack: if the line hits (valid & tag match), update the cached word. Misses do not allocate. Go to IDLE.
- mem_req is asserted only in REFILL/WRITE. mem_addr/mem_we/mem_wdata stay stable while mem_req=1. mem_ack is ignored when mem_req=0.
- Address wrap: base + 4*counter never carries out of the line (counter < LINE_WORDS).
- Back-to-back requests to a just-refilled or just-written line hit with no extra cycle.
- Reset mid-operation (reset=0 at an edge): state → IDLE, counter=0, all valid cleared. A partial refill is discarded.
- Reset outputs, registered in the cycle after reset: stall=0 (if no cpu_req), mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata = array contents (don't-care).

Optional Feature:
- DCACHE_STATS_EN defined: adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments once per load that completes as a hit on first presentation in IDLE.
  - miss_count increments once per load that enters REFILL.
  - Stores are not counted. Counters wrap at 2^32-1 → 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then load 0x0000_0040 (miss), memory returns 0x11,0x22,0x33,0x44 with 2-cycle ack latency → mem_addr 0x40,0x44,0x48,0x4C in order; stall=1 throughout; then cpu_rdata=0x11, stall=0.
- Following load 0x0000_0048 → hit, cpu_rdata=0x33, stall=0 same cycle, mem_req stays 0.
- Store 0xDEAD_BEEF to 0x0000_0044 (hit) → mem_req=1, mem_we=1, mem_addr=0x44; stall drops on the ack cycle; subsequent load 0x44 hits returning 0xDEAD_BEEF.
- Store to 0x0000_1000 (miss) → write-through only; a following load 0x1000 misses and refills.
- Conflict: load 0x0000_0040, then 0x0000_0140 (same index 4, different tag) → second load misses and refills; reload of 0x40 misses again.
- reset=0 during the 3rd refill word → mem_req=0 next cycle, FSM IDLE; load 0x40 afterward misses and refills all 4 words; with DCACHE_STATS_EN, counters read 0 after reset.
